// File: rtl/fifo_wr_stage_if.sv
// Stream-side and FIFO-side signal bundle of the write-side elastic front end.
// master = the stage itself, slave = its surroundings (upstream source + pointer logic).
interface fifo_wr_stage_if #(
    parameter int DSIZE = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [DSIZE-1:0] s_data;
    logic             s_last;
    logic             wfull;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wlast;

    modport master (
        input  s_valid, s_data, s_last, wfull,
        output s_ready, winc, wdata, wlast
    );

    modport slave (
        output s_valid, s_data, s_last, wfull,
        input  s_ready, winc, wdata, wlast
    );
endinterface

// File: rtl/fifo_wr_stage.sv
// Two-entry skid buffer feeding the async FIFO write port, with word/packet/stall
// statistics. A word commits on an edge where winc is high and wfull is low.
module fifo_wr_stage #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic            wclk,
    input  logic            wrst,
    input  logic            flush,
    fifo_wr_stage_if.master bus,
    output logic [CNTW-1:0] word_cnt,
    output logic [CNTW-1:0] pkt_cnt,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state, state_nxt;
    logic             s_ready_q;
    logic [DSIZE-1:0] out_d, skid_d;
    logic             out_l, skid_l;
    logic             out_v;
    logic             push, pop;
    logic             load_out, out_from_skid, load_skid;

    // The output register is valid in ONE and TWO; the skid entry only in TWO.
    assign out_v = (state != EMPTY);
    assign push  = bus.s_valid & s_ready_q;
    assign pop   = out_v & ~bus.wfull;

    assign bus.s_ready = s_ready_q;
    assign bus.winc    = out_v;
    assign bus.wdata   = out_d;
    assign bus.wlast   = out_l;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_nxt     = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_out = 1'b1;
                end else if (push) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt     = ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wrst) begin
            // NOTE: the data registers are reset too, because wdata/wlast must read 0 after reset.
            state     <= EMPTY;
            s_ready_q <= 1'b0;
            out_d     <= '0;
            out_l     <= 1'b0;
            skid_d    <= '0;
            skid_l    <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_ready_q <= (state_nxt != TWO);
            if (load_out) begin
                out_d <= out_from_skid ? skid_d : bus.s_data;
                out_l <= out_from_skid ? skid_l : bus.s_last;
            end
            if (load_skid) begin
                skid_d <= bus.s_data;
                skid_l <= bus.s_last;
            end
        end
    end

    // Statistics follow the pointer logic's view, so a pop during flush still counts.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            word_cnt  <= '0;
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (pop && out_l) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (out_v && bus.wfull && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
